// File: rtl/qed_sched.sv
// qed_sched: issues queued originals' duplicates, drains with NOPs, pulses a check.
// Optional feature macro QED_REMAP_EN: remaps duplicate rd/rs1/rs2 into x16..x31.
module qed_sched #(
  parameter int DEPTH      = 8,
  parameter int NOP_CYCLES = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  input  logic                     exec_dup,
  output logic [31:0]              instr_out,
  output logic                     dup_mode,
  output logic                     qed_check,
  output logic [$clog2(DEPTH):0]   orig_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0]   NOP      = 32'h0000_0013;
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [3:0]    DRAIN_LD = 4'(NOP_CYCLES);

  typedef enum logic [1:0] {
    ORIG,
    DUP,
    DRAIN,
    CHECK
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic [3:0]    drain_cnt;
  logic [3:0]    drain_nxt;
  logic [31:0]   instr_nxt;
  logic [31:0]   dup_instr;
  logic          accept;
  logic [31:0]   fifo [DEPTH];

`ifdef QED_REMAP_EN
  function automatic logic [4:0] remap(input logic [4:0] r);
    return (r == 5'd0) ? r : (r | 5'b10000);
  endfunction

  assign dup_instr = {
    in_instr[31:25],
    remap(in_instr[24:20]),
    remap(in_instr[19:15]),
    in_instr[14:12],
    remap(in_instr[11:7]),
    in_instr[6:0]
  };
`else
  assign dup_instr = in_instr;
`endif

  assign in_ready = (state == ORIG) && (orig_count < FULL);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = orig_count;
    drain_nxt  = drain_cnt;
    instr_nxt  = NOP;
    unique case (state)
      ORIG: begin
        if (accept) begin
          instr_nxt  = in_instr;
          wr_ptr_nxt = wr_ptr + 1'b1;
          count_nxt  = orig_count + 1'b1;
        end
        // a same-cycle accept counts toward the queue being non-empty
        if ((exec_dup && (count_nxt != '0)) ||
            (count_nxt == FULL)) begin
          state_nxt = DUP;
        end
      end
      DUP: begin
        instr_nxt  = fifo[rd_ptr];
        rd_ptr_nxt = rd_ptr + 1'b1;
        count_nxt  = orig_count - 1'b1;
        if (orig_count == CW'(1)) begin
          state_nxt = DRAIN;
          drain_nxt = DRAIN_LD;
        end
      end
      DRAIN: begin
        drain_nxt = drain_cnt - 1'b1;
        if (drain_cnt <= 4'd1) begin
          state_nxt = CHECK;
          drain_nxt = '0;
        end
      end
      CHECK: begin
        wr_ptr_nxt = '0;
        rd_ptr_nxt = '0;
        state_nxt  = ORIG;
      end
      default: begin
        state_nxt = ORIG;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ORIG;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      orig_count <= '0;
      drain_cnt  <= '0;
      instr_out  <= NOP;
      dup_mode   <= 1'b0;
      qed_check  <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      rd_ptr     <= rd_ptr_nxt;
      orig_count <= count_nxt;
      drain_cnt  <= drain_nxt;
      instr_out  <= instr_nxt;
      dup_mode   <= (state == DUP);
      qed_check  <= (state == CHECK);
    end
  end

  // storage needs no reset: pointers and count define validity
  always_ff @(posedge clk) begin
    if (accept) begin
      fifo[wr_ptr] <= dup_instr;
    end
  end

endmodule

// File: doc/qed_sched.md
QED_SCHED -- requirements
Module: qed_sched

Interface
REQ-001 Parameter DEPTH, default 8, originals held for duplication; power of two, 2..32.
REQ-002 Parameter NOP_CYCLES, default 5, pipeline-drain NOPs issued after the last duplicate; 1..15.
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 RESET_N  input  1  asynchronous active-low reset.
REQ-005 IN_VALID  input  1  IN_INSTR holds an original instruction (cutpoint source).
REQ-006 IN_INSTR  input  32  original RV32I instruction.
REQ-007 IN_READY  output  1  scheduler accepts IN_INSTR this cycle.
REQ-008 EXEC_DUP  input  1  request to switch from original to duplicate issue.
REQ-009 INSTR_OUT  output  32  registered instruction to the core's INSTR port.
REQ-010 DUP_MODE  output  1  high while duplicates are being issued.
REQ-011 QED_CHECK  output  1  one-cycle pulse: original/duplicate register halves due for comparison.
REQ-012 ORIG_COUNT  output  $clog2(DEPTH)+1  originals queued, not yet duplicated.

Function
REQ-013 States: ORIG, DUP, DRAIN, CHECK; reset state ORIG.
REQ-014 IN_READY = (state==ORIG) && (ORIG_COUNT < DEPTH); combinational from state and count.
REQ-015 Accept = IN_VALID && IN_READY; on accept, INSTR_OUT <= IN_INSTR next edge, duplicate form pushed to FIFO, ORIG_COUNT +1.
REQ-016 Any cycle with nothing to issue: INSTR_OUT <= 32'h00000013 (NOP).
REQ-017 ORIG->DUP when EXEC_DUP high and ORIG_COUNT>0, or when ORIG_COUNT reaches DEPTH; accept in the same cycle as EXEC_DUP is honoured and included in the queue.
REQ-018 EXEC_DUP with ORIG_COUNT==0 ignored; remain in ORIG.
REQ-019 DUP: pop one entry per cycle, INSTR_OUT <= entry, ORIG_COUNT -1; DUP_MODE high; IN_READY low.
REQ-020 DUP->DRAIN on the edge popping the last entry; duplicate order equals original order.
REQ-021 DRAIN: issue exactly NOP_CYCLES NOPs via a down-counter, then CHECK.
REQ-022 CHECK: one cycle, QED_CHECK=1, INSTR_OUT=NOP, FIFO pointers cleared; next state ORIG.
REQ-023 FIFO pointers wrap modulo DEPTH; full/empty derived from ORIG_COUNT, no overflow/underflow possible.
REQ-024 EXEC_DUP outside ORIG ignored, not latched.
REQ-025 All outputs registered except IN_READY; latency accept->INSTR_OUT = 1 cycle.

Reset
REQ-026 RESET_N low asynchronously forces: state ORIG, INSTR_OUT NOP, DUP_MODE 0, QED_CHECK 0, ORIG_COUNT 0, pointers 0, drain counter 0.
REQ-027 Reset mid-DUP/DRAIN discards queued originals; no duplicate issued after release.
REQ-028 First accept possible on the first rising edge after RESET_N deasserts.

Configuration
REQ-029 Macro QED_REMAP_EN defined: duplicate = original with rd[11:7], rs1[19:15], rs2[24:20] each OR 5'b10000 when nonzero; zero fields kept as x0.
REQ-030 QED_REMAP_EN undefined: duplicate = original bit-exact (wiring smoke test); all other behaviour identical.

Verification
REQ-031 Reset, IN_VALID=0 for 4 cycles -> INSTR_OUT=0x00000013, IN_READY=1, ORIG_COUNT=0, QED_CHECK never 1.
REQ-032 QED_REMAP_EN: accept 0x002081B3 (add x3,x1,x2), then EXEC_DUP -> INSTR_OUT 0x002081B3, next cycle 0x0128 89B3 -> i.e. 0x012889B3 (add x19,x17,x18), 5 NOPs, QED_CHECK pulse, back to ORIG.
REQ-033 DEPTH=8, IN_VALID held high -> 8 accepts, IN_READY drops, auto-DUP issues 8 duplicates in order, ORIG_COUNT 8->0.
REQ-034 EXEC_DUP with ORIG_COUNT=0 -> state stays ORIG, DUP_MODE=0.
REQ-035 RESET_N low after 2nd of 4 duplicates -> outputs at reset values immediately; after release no duplicate and no QED_CHECK appears.
REQ-036 QED_REMAP_EN undefined, accept 0x00500093 (addi x1,x0,5) + EXEC_DUP -> duplicate 0x00500093.
